register_file: RTL and testbench
================================

// Module: register_file
// PURPOSE
//  Architectural register file with rename tags; the write-side peer of the reorder buffer.
//  Dispatch tags each destination register with its ROB slot id.
//  The ROB's in-order register writeback retires the value and clears the tag.
//  Dispatch reads operands here, getting either a ready value or the ROB id to wait on.
// PARAMETERS
//  NUM_REGS   32  architectural registers (x0 hardwired to zero)
//  TAG_WIDTH  5   ROB slot id width (32-entry ROB)
// PORTS
//  clk               in   1   single clock, rising edge
//  rst               in   1   synchronous reset, active-high
//  flush             in   1   ROB mispredict reset (reset_en): drop all pending tags
//  rename_en         in   1   dispatch allocates ROB slot for a register-writing instr
//  rename_regid      in   5   destination architectural register
//  rename_vregid     in   5   ROB slot id allocated (ROB next_id)
//  commit_en         in   1   ROB register_writeback_en
//  commit_regid      in   5   ROB register_writeback_id
//  commit_vregid     in   5   ROB register_writeback_dependency (slot being retired)
//  commit_val        in   32  ROB register_writeback_val
//  query_regid1      in   5   operand 1 register
//  query_regid2      in   5   operand 2 register
//  query_busy1       out  1   1 = operand 1 pending in ROB
//  query_vregid1     out  5   ROB slot producing operand 1 (valid when busy)
//  query_val1        out  32  operand 1 value (valid when not busy)
//  query_busy2/query_vregid2/query_val2   out 1/5/32   same for operand 2
// BEHAVIOUR
//  - State per reg: val[31:0], busy, tag[4:0].
//  - Sync reset: all val=0, busy=0, tag=0; rst dominates all inputs in that cycle.
//  - Query outputs are combinational and reflect only pre-edge state and the commit bypass.
//  - After reset with regid=0: query_busy=0, query_val=0, query_vregid=0.
//  - x0: reads val 0 / busy 0 always; rename and commit to x0 ignored.
//  - Rename (posedge, rename_en & regid!=0): busy<=1, tag<=rename_vregid.
//  - A re-rename overwrites the tag; the newest producer wins.
//  - Commit (posedge, commit_en & regid!=0): val<=commit_val unconditionally, since commits are in order.
//  - Commit clears busy only if busy & tag==commit_vregid, with no same-cycle rename of that reg.
//  - Rename+commit same reg same cycle: val written; busy=1 and tag=rename_vregid (rename wins tag).
//  - Query bypass: if commit_en, commit_regid==query_regid!=0, and the reg is busy with tag==commit_vregid:
//    query_busy=0, query_val=commit_val.
//  - Query otherwise returns stored busy/tag/val.
//  - Query ignores same-cycle rename, so an instruction with rs==rd sees the older producer.
//  - Flush (posedge): all busy<=0; same-cycle rename ignored.
//  - Flush+commit same cycle (jalr mispredict retire): commit value still written, then all busy clear.
//  - Query in a flush cycle still uses pre-edge state (dispatch is squashed by the ROB reset anyway).
//  - Latency: rename/commit visible to queries the next cycle; commit also visible the same cycle via bypass.
//  - No backpressure: rename_en and commit_en are accepted every cycle.
// TESTING
//  1 Reset, then query x5/x0 -> busy=0, val=0 for both.
//  2 Rename x5->tag 3; next cycle query x5 -> busy=1, vregid=3.
//    Commit x5/tag 3/val 0x1234 -> same-cycle query busy=0, val=0x1234; stays so after the edge.
//  3 Stale tag: rename x7->2, then x7->9; commit x7/tag 2/val 0xAA -> x7 busy=1, tag=9, val=0xAA.
//    Commit x7/tag 9/val 0xBB -> busy=0, val=0xBB.
//  4 Same-cycle rename x4->6 and commit x4/tag 1/val 0x55 (x4 was tag 1).
//    -> x4 busy=1, tag=6, val=0x55; same-cycle query x4 gives busy=0, val=0x55 (old producer).
//  5 x0: rename x0->4, commit x0 val 0xFFFFFFFF -> query x0 busy=0, val=0 always.
//  6 Flush: x1,x2 busy, flush with commit x1/tag match/val 0x10 and rename x3->8.
//    -> next cycle x1 val=0x10 busy=0, x2 busy=0, x3 busy=0.
//    rst asserted mid-stream -> all vals 0.

Source files
------------

// File: rtl/register_file.sv
// Architectural register file with ROB rename tags: dispatch tags destinations,
// in-order commit retires values, and operand queries see a same-cycle commit bypass.
module register_file #(
  parameter int NUM_REGS  = 32,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 rename_en,
  input  logic [4:0]           rename_regid,
  input  logic [TAG_WIDTH-1:0] rename_vregid,
  input  logic                 commit_en,
  input  logic [4:0]           commit_regid,
  input  logic [TAG_WIDTH-1:0] commit_vregid,
  input  logic [31:0]          commit_val,
  input  logic [4:0]           query_regid1,
  input  logic [4:0]           query_regid2,
  output logic                 query_busy1,
  output logic [TAG_WIDTH-1:0] query_vregid1,
  output logic [31:0]          query_val1,
  output logic                 query_busy2,
  output logic [TAG_WIDTH-1:0] query_vregid2,
  output logic [31:0]          query_val2
);

  typedef struct packed {
    logic                 busy;
    logic [TAG_WIDTH-1:0] tag;
    logic [31:0]          val;
  } query_t;

  logic [31:0]          val_q [NUM_REGS];
  logic [31:0]          val_d [NUM_REGS];
  logic [TAG_WIDTH-1:0] tag_q [NUM_REGS];
  logic [TAG_WIDTH-1:0] tag_d [NUM_REGS];
  logic [NUM_REGS-1:0]  busy_q;
  logic [NUM_REGS-1:0]  busy_d;

  logic   rename_live;
  query_t query1;
  query_t query2;

  assign rename_live = rename_en && !flush;

  // x0 is never written, so it keeps its reset value of zero forever.
  always_comb begin
    val_d  = val_q;
    tag_d  = tag_q;
    busy_d = busy_q;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (commit_en && commit_regid == 5'(i)) begin
        val_d[i] = commit_val;
        if (busy_q[i] && tag_q[i] == commit_vregid) begin
          busy_d[i] = 1'b0;
        end
      end
      if (rename_live && rename_regid == 5'(i)) begin
        busy_d[i] = 1'b1;
        tag_d[i]  = rename_vregid;
      end
    end
    if (flush) begin
      busy_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i] <= '0;
        tag_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      val_q  <= val_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

  // Reads see pre-edge state only; a retiring commit to the awaited tag is forwarded.
  function automatic query_t lookup(input logic [4:0] regid);
    query_t q;
    q = '{busy: 1'b0, tag: '0, val: '0};
    if (regid != 5'd0) begin
      q.tag = tag_q[regid];
      if (commit_en && commit_regid == regid && busy_q[regid] &&
          tag_q[regid] == commit_vregid) begin
        q.busy = 1'b0;
        q.val  = commit_val;
      end else begin
        q.busy = busy_q[regid];
        q.val  = val_q[regid];
      end
    end
    return q;
  endfunction

  always_comb begin
    query1 = lookup(query_regid1);
    query2 = lookup(query_regid2);
  end

  assign query_busy1   = query1.busy;
  assign query_vregid1 = query1.tag;
  assign query_val1    = query1.val;
  assign query_busy2   = query2.busy;
  assign query_vregid2 = query2.tag;
  assign query_val2    = query2.val;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios with hand-derived
// expectations followed by randomized traffic checked against an array model.
module tb_register_file;

   logic        clk;
   logic        rst;
   logic        flush;
   logic        rename_en;
   logic [4:0]  rename_regid;
   logic [4:0]  rename_vregid;
   logic        commit_en;
   logic [4:0]  commit_regid;
   logic [4:0]  commit_vregid;
   logic [31:0] commit_val;
   logic [4:0]  query_regid1;
   logic [4:0]  query_regid2;
   logic        query_busy1;
   logic [4:0]  query_vregid1;
   logic [31:0] query_val1;
   logic        query_busy2;
   logic [4:0]  query_vregid2;
   logic [31:0] query_val2;

   int checkCount;
   int errorCount;

   // Architectural view of the register file: value, pending flag and producer tag.
   logic [31:0] modelVal  [32];
   logic        modelBusy [32];
   logic [4:0]  modelTag  [32];

   register_file dut (
      .clk           (clk),
      .rst           (rst),
      .flush         (flush),
      .rename_en     (rename_en),
      .rename_regid  (rename_regid),
      .rename_vregid (rename_vregid),
      .commit_en     (commit_en),
      .commit_regid  (commit_regid),
      .commit_vregid (commit_vregid),
      .commit_val    (commit_val),
      .query_regid1  (query_regid1),
      .query_regid2  (query_regid2),
      .query_busy1   (query_busy1),
      .query_vregid1 (query_vregid1),
      .query_val1    (query_val1),
      .query_busy2   (query_busy2),
      .query_vregid2 (query_vregid2),
      .query_val2    (query_val2)
   );

   // 10 ns clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Expected operand read: x0 is zero, a retiring commit of the awaited tag is forwarded.
   task automatic expectedRead(input logic [4:0] r, output logic busy,
                               output logic [4:0] tag, output logic [31:0] val);
      busy = 1'b0;
      tag  = 5'd0;
      val  = 32'd0;
      if (r != 5'd0) begin
         tag = modelTag[r];
         if (commit_en && commit_regid == r && modelBusy[r] && modelTag[r] == commit_vregid) begin
            val = commit_val;
         end else begin
            busy = modelBusy[r];
            val  = modelVal[r];
         end
      end
   endtask

   // Compare both query ports against the model; tags only matter while pending.
   task automatic checkAgainstModel();
      logic        b;
      logic [4:0]  t;
      logic [31:0] v;
      expectedRead(query_regid1, b, t, v);
      checkOutput("q1_busy", {31'd0, query_busy1}, {31'd0, b});
      checkOutput("q1_val", query_val1, v);
      if (b) checkOutput("q1_vregid", {27'd0, query_vregid1}, {27'd0, t});
      expectedRead(query_regid2, b, t, v);
      checkOutput("q2_busy", {31'd0, query_busy2}, {31'd0, b});
      checkOutput("q2_val", query_val2, v);
      if (b) checkOutput("q2_vregid", {27'd0, query_vregid2}, {27'd0, t});
   endtask

   // Drive one cycle of inputs and check the combinational reads before the edge.
   task automatic applyStimulus(input logic r, input logic f,
                                input logic ren, input logic [4:0] rreg, input logic [4:0] rtag,
                                input logic cen, input logic [4:0] creg, input logic [4:0] ctag,
                                input logic [31:0] cval, input logic [4:0] q1, input logic [4:0] q2);
      rst           = r;
      flush         = f;
      rename_en     = ren;
      rename_regid  = rreg;
      rename_vregid = rtag;
      commit_en     = cen;
      commit_regid  = creg;
      commit_vregid = ctag;
      commit_val    = cval;
      query_regid1  = q1;
      query_regid2  = q2;
      #2;
      if (!rst) checkAgainstModel();
   endtask

   // Advance one clock and apply the architectural update rules to the model.
   task automatic tick();
      logic retire;
      logic renameLive;
      @(posedge clk);
      if (rst) begin
         for (int i = 0; i < 32; i++) begin
            modelVal[i]  = 32'd0;
            modelBusy[i] = 1'b0;
            modelTag[i]  = 5'd0;
         end
      end else begin
         renameLive = rename_en && !flush && rename_regid != 5'd0;
         if (commit_en && commit_regid != 5'd0) begin
            retire = modelBusy[commit_regid] && modelTag[commit_regid] == commit_vregid;
            modelVal[commit_regid] = commit_val;
            if (retire) modelBusy[commit_regid] = 1'b0;
         end
         if (renameLive) begin
            modelBusy[rename_regid] = 1'b1;
            modelTag[rename_regid]  = rename_vregid;
         end
         if (flush) begin
            for (int i = 0; i < 32; i++) modelBusy[i] = 1'b0;
         end
      end
      #1;
   endtask

   task automatic idle(input logic [4:0] q1, input logic [4:0] q2);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, q1, q2);
   endtask

   initial begin
      logic [4:0]  rreg;
      logic [4:0]  creg;
      logic [4:0]  ctag;
      checkCount = 0;
      errorCount = 0;
      for (int i = 0; i < 32; i++) begin
         modelVal[i]  = 32'hDEAD_BEEF;
         modelBusy[i] = 1'b1;
         modelTag[i]  = 5'd31;
      end

      // Reset, then x5 and x0 read as idle zeros.
      applyStimulus(1, 0, 1, 5, 7, 1, 5, 7, 32'h1111, 5, 0);
      tick();
      idle(5, 0);
      checkOutput("rst_x5_busy", {31'd0, query_busy1}, 32'd0);
      checkOutput("rst_x5_val", query_val1, 32'd0);
      checkOutput("rst_x5_vregid", {27'd0, query_vregid1}, 32'd0);
      checkOutput("rst_x0_busy", {31'd0, query_busy2}, 32'd0);
      checkOutput("rst_x0_val", query_val2, 32'd0);
      checkOutput("rst_x0_vregid", {27'd0, query_vregid2}, 32'd0);
      tick();

      // Rename x5 to tag 3, then retire it through the bypass.
      applyStimulus(0, 0, 1, 5, 3, 0, 0, 0, 0, 5, 0);
      tick();
      idle(5, 0);
      checkOutput("ren_x5_busy", {31'd0, query_busy1}, 32'd1);
      checkOutput("ren_x5_vregid", {27'd0, query_vregid1}, 32'd3);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 1, 5, 3, 32'h1234, 5, 0);
      checkOutput("byp_x5_busy", {31'd0, query_busy1}, 32'd0);
      checkOutput("byp_x5_val", query_val1, 32'h1234);
      tick();
      idle(5, 0);
      checkOutput("cmt_x5_busy", {31'd0, query_busy1}, 32'd0);
      checkOutput("cmt_x5_val", query_val1, 32'h1234);
      tick();

      // Stale commit of an overwritten tag writes the value but leaves x7 pending.
      applyStimulus(0, 0, 1, 7, 2, 0, 0, 0, 0, 7, 0);
      tick();
      applyStimulus(0, 0, 1, 7, 9, 0, 0, 0, 0, 7, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 1, 7, 2, 32'hAA, 7, 0);
      tick();
      idle(7, 0);
      checkOutput("stale_x7_busy", {31'd0, query_busy1}, 32'd1);
      checkOutput("stale_x7_vregid", {27'd0, query_vregid1}, 32'd9);
      checkOutput("stale_x7_val", query_val1, 32'hAA);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 1, 7, 9, 32'hBB, 0, 7);
      tick();
      idle(0, 7);
      checkOutput("new_x7_busy", {31'd0, query_busy2}, 32'd0);
      checkOutput("new_x7_val", query_val2, 32'hBB);
      tick();

      // Same-cycle rename and commit of x4: reader sees old producer, rename keeps the tag.
      applyStimulus(0, 0, 1, 4, 1, 0, 0, 0, 0, 4, 0);
      tick();
      applyStimulus(0, 0, 1, 4, 6, 1, 4, 1, 32'h55, 4, 0);
      checkOutput("rc_x4_same_busy", {31'd0, query_busy1}, 32'd0);
      checkOutput("rc_x4_same_val", query_val1, 32'h55);
      tick();
      idle(4, 0);
      checkOutput("rc_x4_busy", {31'd0, query_busy1}, 32'd1);
      checkOutput("rc_x4_vregid", {27'd0, query_vregid1}, 32'd6);
      checkOutput("rc_x4_val", query_val1, 32'h55);
      tick();

      // x0 ignores rename and commit.
      applyStimulus(0, 0, 1, 0, 4, 1, 0, 4, 32'hFFFF_FFFF, 0, 0);
      checkOutput("x0_same_val", query_val1, 32'd0);
      tick();
      idle(0, 0);
      checkOutput("x0_busy", {31'd0, query_busy1}, 32'd0);
      checkOutput("x0_val", query_val1, 32'd0);
      tick();

      // Flush with a matching commit on x1 and a rename of x3.
      applyStimulus(0, 0, 1, 1, 11, 0, 0, 0, 0, 1, 2);
      tick();
      applyStimulus(0, 0, 1, 2, 12, 0, 0, 0, 0, 1, 2);
      tick();
      applyStimulus(0, 1, 1, 3, 8, 1, 1, 11, 32'h10, 1, 2);
      tick();
      idle(1, 2);
      checkOutput("fl_x1_busy", {31'd0, query_busy1}, 32'd0);
      checkOutput("fl_x1_val", query_val1, 32'h10);
      checkOutput("fl_x2_busy", {31'd0, query_busy2}, 32'd0);
      tick();
      idle(3, 0);
      checkOutput("fl_x3_busy", {31'd0, query_busy1}, 32'd0);
      tick();

      // Randomized traffic on a small register window to force collisions.
      for (int n = 0; n < 400; n++) begin
         rreg = 5'($urandom_range(0, 7));
         creg = 5'($urandom_range(0, 7));
         ctag = ($urandom_range(0, 1) == 0) ? modelTag[creg] : 5'($urandom_range(0, 31));
         applyStimulus(($urandom_range(0, 99) == 0), ($urandom_range(0, 29) == 0),
                       $urandom_range(0, 1) == 1, rreg, 5'($urandom_range(0, 31)),
                       $urandom_range(0, 1) == 1, creg, ctag, $urandom,
                       5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
         tick();
      end

      // Mid-stream reset with active traffic clears every register value.
      applyStimulus(1, 1, 1, 6, 4, 1, 6, 4, 32'hCAFE, 6, 6);
      tick();
      for (int r = 0; r < 32; r++) begin
         idle(5'(r), 5'(r));
         checkOutput("rst2_val", query_val1, 32'd0);
         checkOutput("rst2_busy", {31'd0, query_busy2}, 32'd0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule
